crc32_eth_word: RTL and testbench

- Word-parallel Ethernet CRC-32 accumulator. It absorbs one 32-bit data word on every rising clock edge.
- It exposes the raw 32-bit LFSR state. Final FCS formatting (bit-reversal and inversion) happens downstream.
- It sits in the Ethernet TX/RX datapath beside the frame word stream.

---
 rtl/crc32_eth_pkg.sv | 32 +++
 rtl/crc32_next_comb.sv | 38 +++
 rtl/crc32_eth_word.sv | 44 ++++
 tb/tb_crc32_eth_word.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc32_eth_pkg.sv
// ============================================================================
// Module   : crc32_eth_pkg
// Summary  : Shared CRC-32 types, constants and the bit-serial next-state function
// Revision : 1.0
// ============================================================================
`default_nettype none

package crc32_eth_pkg;

    localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

    typedef logic [31:0] crc32_t;

    // MSB-first absorption: d[31] enters the LFSR first.
    function automatic crc32_t crc32_next(crc32_t s, crc32_t d, crc32_t poly);
        crc32_t c;
        logic   fb;
        c = s;
        for (int k = 0; k < 32; k++) begin
            fb = c[31] ^ d[31-k];
            c  = {c[30:0], 1'b0};
            if (fb) begin
                c = c ^ poly;
            end
        end
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/crc32_next_comb.sv
// ============================================================================
// Module   : crc32_next_comb
// Summary  : Single-cycle combinational CRC-32 next-state XOR network
// Revision : 1.0
// ============================================================================
`default_nettype none

module crc32_next_comb
    import crc32_eth_pkg::*;
#(
    parameter logic [31:0] POLY = CRC32_POLY
) (
    input  logic [31:0] s,
    input  logic [31:0] d,
    output logic [31:0] nxt
);

    // One stage per absorbed bit; each stage reads its predecessor's output.
    for (genvar k = 0; k < 32; k++) begin : g_stage
        logic [31:0] w_in;
        logic [31:0] w_out;
        logic        w_fb;

        if (k == 0) begin : g_first
            assign w_in = s;
        end else begin : g_rest
            assign w_in = g_stage[k-1].w_out;
        end

        assign w_fb  = w_in[31] ^ d[31-k];
        assign w_out = {w_in[30:0], 1'b0} ^ (POLY & {32{w_fb}});
    end

    assign nxt = g_stage[31].w_out;

endmodule

`default_nettype wire

// File: rtl/crc32_eth_word.sv
// ============================================================================
// Module   : crc32_eth_word
// Summary  : Word-parallel Ethernet CRC-32 accumulator exposing the raw LFSR state
// Revision : 1.0
// ============================================================================
`default_nettype none

module crc32_eth_word
    import crc32_eth_pkg::*;
#(
    parameter logic [31:0] POLY = CRC32_POLY,
    parameter logic [31:0] INIT = CRC32_INIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in,
    output logic [31:0] dat_out
);

    crc32_t state_q;
    crc32_t state_d;

    crc32_next_comb #(
        .POLY (POLY)
    ) u_next (
        .s   (state_q),
        .d   (in),
        .nxt (state_d)
    );

    // No enable: every edge out of reset consumes a word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    assign dat_out = state_q;

endmodule

`default_nettype wire

// File: tb/tb_crc32_eth_word.sv
// ============================================================================
// Module   : tb_crc32_eth_word
// Summary  : Directed self-checking bench for crc32_eth_word
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_crc32_eth_word;
    import crc32_eth_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] in;
    logic [31:0] dat_out;
    logic        rst1;
    logic [31:0] in1;
    logic [31:0] dat_out1;

    int checks;
    int failures;

    crc32_eth_word u_dut (
        .clk     (clk),
        .rst     (rst),
        .in      (in),
        .dat_out (dat_out)
    );

    crc32_eth_word #(
        .POLY (32'h1EDC6F41),
        .INIT (32'h00000000)
    ) u_dut_alt (
        .clk     (clk),
        .rst     (rst1),
        .in      (in1),
        .dat_out (dat_out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // (s ^ d) * x^32 mod P, computed by multiplying out the combined word.
    function automatic logic [31:0] mdl(logic [31:0] s, logic [31:0] d, logic [31:0] poly);
        logic [31:0] r;
        logic        msb;
        r = s ^ d;
        for (int i = 0; i < 32; i++) begin
            msb = r[31];
            r   = r << 1;
            if (msb) r = r ^ poly;
        end
        return r;
    endfunction

    function automatic logic [31:0] bitrev32(logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // Conventional reflected byte-wise Ethernet CRC over the same bit stream.
    function automatic logic [31:0] fcs_golden(logic [31:0] words[64]);
        logic [31:0] crc;
        logic [7:0]  b;
        crc = 32'hFFFFFFFF;
        for (int w = 0; w < 64; w++) begin
            for (int by = 0; by < 4; by++) begin
                for (int j = 0; j < 8; j++) b[j] = words[w][31 - 8*by - j];
                crc = crc ^ {24'h0, b};
                for (int j = 0; j < 8; j++) begin
                    if (crc[0]) crc = (crc >> 1) ^ 32'hEDB88320;
                    else        crc = crc >> 1;
                end
            end
        end
        return ~crc;
    endfunction

    task automatic step(input logic [31:0] w);
        in = w;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        in  = 32'hDEADBEEF;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] exp;
        rst = 1'b1;
        in  = 32'hDEADBEEF;
        #1;
        checks++;
        if (dat_out !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL reset_initial: got %h want %h", dat_out, 32'hFFFFFFFF);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (dat_out !== 32'hFFFFFFFF) begin
                failures++;
                $display("FAIL reset_hold[%0d]: got %h want %h", i, dat_out, 32'hFFFFFFFF);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (dat_out !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL reset_release_no_edge: got %h want %h", dat_out, 32'hFFFFFFFF);
        end
        step(32'hDEADBEEF);
        exp = mdl(32'hFFFFFFFF, 32'hDEADBEEF, 32'h04C11DB7);
        checks++;
        if (dat_out !== exp) begin
            failures++;
            $display("FAIL reset_first_word: got %h want %h", dat_out, exp);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (dat_out !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL reset_async_midcycle: got %h want %h", dat_out, 32'hFFFFFFFF);
        end
    endtask

    task automatic test_cancel;
        do_reset();
        step(32'hFFFFFFFF);
        checks++;
        if (dat_out !== 32'h00000000) begin
            failures++;
            $display("FAIL cancel_first: got %h want %h", dat_out, 32'h0);
        end
        for (int i = 0; i < 3; i++) begin
            step(32'h00000000);
            checks++;
            if (dat_out !== 32'h00000000) begin
                failures++;
                $display("FAIL cancel_zero[%0d]: got %h want %h", i, dat_out, 32'h0);
            end
        end
    endtask

    task automatic test_taps;
        do_reset();
        step(32'hFFFFFFFE);
        checks++;
        if (dat_out !== 32'h04C11DB7) begin
            failures++;
            $display("FAIL tap_x32: got %h want %h", dat_out, 32'h04C11DB7);
        end
        step(32'h04C11DB7);
        checks++;
        if (dat_out !== 32'h00000000) begin
            failures++;
            $display("FAIL tap_cancel: got %h want %h", dat_out, 32'h0);
        end
        do_reset();
        step(32'hFFFFFFFD);
        checks++;
        if (dat_out !== 32'h09823B6E) begin
            failures++;
            $display("FAIL tap_x33: got %h want %h", dat_out, 32'h09823B6E);
        end
    endtask

    task automatic test_reference;
        logic [31:0] words[64];
        logic [31:0] exp;
        logic [31:0] fcs;
        int          bad;
        bad = 0;
        do_reset();
        exp = 32'hFFFFFFFF;
        for (int i = 0; i < 64; i++) begin
            words[i] = $urandom;
            step(words[i]);
            exp = mdl(exp, words[i], 32'h04C11DB7);
            checks++;
            if (dat_out !== exp) begin
                failures++;
                bad++;
                if (bad < 5) $display("FAIL reference[%0d]: got %h want %h", i, dat_out, exp);
            end
        end
        fcs = fcs_golden(words);
        checks++;
        if (~bitrev32(dat_out) !== fcs) begin
            failures++;
            $display("FAIL reference_fcs: got %h want %h", ~bitrev32(dat_out), fcs);
        end
    endtask

    task automatic test_back_to_back_reset;
        logic [31:0] words[10];
        logic [31:0] first[10];
        logic [31:0] exp;
        do_reset();
        exp = 32'hFFFFFFFF;
        for (int i = 0; i < 10; i++) begin
            words[i] = $urandom;
            step(words[i]);
            first[i] = dat_out;
            exp = mdl(exp, words[i], 32'h04C11DB7);
            checks++;
            if (dat_out !== exp) begin
                failures++;
                $display("FAIL midreset_first[%0d]: got %h want %h", i, dat_out, exp);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (dat_out !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL midreset_pulse: got %h want %h", dat_out, 32'hFFFFFFFF);
        end
        #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(words[i]);
            checks++;
            if (dat_out !== first[i]) begin
                failures++;
                $display("FAIL midreset_replay[%0d]: got %h want %h", i, dat_out, first[i]);
            end
        end
    endtask

    task automatic test_param;
        logic [31:0] exp;
        checks++;
        if (dat_out1 !== 32'h00000000) begin
            failures++;
            $display("FAIL param_reset: got %h want %h", dat_out1, 32'h0);
        end
        @(negedge clk);
        rst1 = 1'b0;
        in1  = 32'h00000001;
        @(posedge clk);
        #1;
        checks++;
        if (dat_out1 !== 32'h1EDC6F41) begin
            failures++;
            $display("FAIL param_x32: got %h want %h", dat_out1, 32'h1EDC6F41);
        end
        in1 = 32'hA5A5_5A5A;
        exp = mdl(32'h1EDC6F41, 32'hA5A5_5A5A, 32'h1EDC6F41);
        @(posedge clk);
        #1;
        checks++;
        if (dat_out1 !== exp) begin
            failures++;
            $display("FAIL param_second: got %h want %h", dat_out1, exp);
        end
        rst1 = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        in       = 32'hDEADBEEF;
        rst1     = 1'b1;
        in1      = 32'h0;
        test_reset();
        test_cancel();
        test_taps();
        test_reference();
        test_back_to_back_reset();
        test_param();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
